rr_arbiter4: RTL and testbench

Four-way round-robin arbiter that shares one downstream resource (bus, ALU port, memory port) among four requesters. It is the sequential counterpart to the team's 4-bit priority encoders. After reset it resolves ties in the same order as the encoder: bit 3 is highest. After each grant it rotates priority so no requester starves. A grant is held until the owner signals completion, drops its request, or exceeds a hold timeout.

---
 rtl/rr_arbiter4.sv | 112 +++++++++++
 tb/tb_rr_arbiter4.sv | 137 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with hold timeout; one grant active at a time.
// Ports: clk, rst_n (sync, active-low), req[3:0], done -> grant[3:0], grant_id[1:0],
//        grant_valid, timeout (one-cycle pulse on forced release).
module rr_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Last count value before a forced release; unused when MAX_HOLD is 0.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    logic [0:0]       state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       id_q, id_d;
    logic             tmo_q, tmo_d;

    logic       found;
    logic [1:0] pick;
    logic [1:0] idx;

    // Descending cyclic search from last-1; the previous owner comes last.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        idx   = last_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q - 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        id_d    = id_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = 4'b0001 << pick;
                    id_d    = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done || !req[id_q]) begin
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (MAX_HOLD != 0 && cnt_q == HOLD_LAST) begin
                    grant_d = '0;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 2'd0;
            cnt_q   <= '0;
            grant_q <= 4'b0000;
            id_q    <= 2'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = id_q;
    assign grant_valid = |grant_q;
    assign timeout     = tmo_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed testbench for rr_arbiter4 (MAX_HOLD = 4).
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_g(input string tag, input logic [3:0] g,
                         input logic t);
        check({tag, " grant"}, {4'b0, grant}, {4'b0, g});
        check({tag, " valid"}, {7'b0, grant_valid}, {7'b0, |g});
        check({tag, " tmo"}, {7'b0, timeout}, {7'b0, t});
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        tick();
        tick();
        chk_g("reset", 4'b0000, 1'b0);
        check("reset id", {6'b0, grant_id}, 8'd0);

        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        chk_g("prio3", 4'b1000, 1'b0);
        check("prio3 id", {6'b0, grant_id}, 8'd3);

        // Rotation with one done pulse per grant.
        done = 1'b1; tick(); chk_g("rot gap0", 4'b0000, 1'b0);
        done = 1'b0; tick(); chk_g("rot g2", 4'b0100, 1'b0);
        check("rot id2", {6'b0, grant_id}, 8'd2);
        done = 1'b1; tick(); chk_g("rot gap1", 4'b0000, 1'b0);
        done = 1'b0; tick(); chk_g("rot g1", 4'b0010, 1'b0);
        done = 1'b1; tick(); chk_g("rot gap2", 4'b0000, 1'b0);
        done = 1'b0; tick(); chk_g("rot g0", 4'b0001, 1'b0);
        check("rot id0", {6'b0, grant_id}, 8'd0);
        done = 1'b1; tick(); chk_g("rot gap3", 4'b0000, 1'b0);
        done = 1'b0; tick(); chk_g("rot g3", 4'b1000, 1'b0);

        // Fairness skip: last = 3, req = 1001.
        done = 1'b1; tick(); chk_g("fair gap", 4'b0000, 1'b0);
        done = 1'b0; req = 4'b1001;
        tick(); chk_g("fair g0", 4'b0001, 1'b0);
        done = 1'b1; tick(); chk_g("fair gap2", 4'b0000, 1'b0);
        done = 1'b0; tick(); chk_g("fair g3", 4'b1000, 1'b0);

        // Timeout with MAX_HOLD = 4.
        done = 1'b1; tick(); chk_g("tmo pre", 4'b0000, 1'b0);
        done = 1'b0; req = 4'b0010;
        tick(); chk_g("tmo h1", 4'b0010, 1'b0);
        tick(); chk_g("tmo h2", 4'b0010, 1'b0);
        tick(); chk_g("tmo h3", 4'b0010, 1'b0);
        tick(); chk_g("tmo h4", 4'b0010, 1'b0);
        tick(); chk_g("tmo rel", 4'b0000, 1'b1);
        tick(); chk_g("tmo regr", 4'b0010, 1'b0);
        check("tmo id", {6'b0, grant_id}, 8'd1);

        // Request drop by owner 2.
        done = 1'b1; tick(); chk_g("drop pre", 4'b0000, 1'b0);
        done = 1'b0; req = 4'b0100;
        tick(); chk_g("drop g2", 4'b0100, 1'b0);
        req = 4'b0000;
        tick(); chk_g("drop rel", 4'b0000, 1'b0);

        // Stray done while idle.
        done = 1'b1;
        tick(); chk_g("stray1", 4'b0000, 1'b0);
        tick(); chk_g("stray2", 4'b0000, 1'b0);
        done = 1'b0;

        // done and req drop together: plain release.
        req = 4'b0100;
        tick(); chk_g("both g2", 4'b0100, 1'b0);
        done = 1'b1; req = 4'b0000;
        tick(); chk_g("both rel", 4'b0000, 1'b0);
        done = 1'b0;

        // No preemption by req[1] rising during BUSY.
        req = 4'b0100;
        tick(); chk_g("pre g2", 4'b0100, 1'b0);
        req = 4'b0110;
        tick(); chk_g("pre hold1", 4'b0100, 1'b0);
        tick(); chk_g("pre hold2", 4'b0100, 1'b0);

        // Reset mid-grant.
        rst_n = 1'b0;
        tick(); chk_g("midrst", 4'b0000, 1'b0);
        check("midrst id", {6'b0, grant_id}, 8'd0);
        rst_n = 1'b1;
        req = 4'b0110;
        tick(); chk_g("postrst", 4'b0100, 1'b0);
        check("postrst id", {6'b0, grant_id}, 8'd2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
